// File: rtl/or1200_wb_arb2_if.sv
// Wishbone B3 signal bundle used on both arbiter master ports and the shared slave-side port.
interface wb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH/8-1:0] sel;
    logic [DATA_WIDTH-1:0]   dat_w;
    logic [DATA_WIDTH-1:0]   dat_r;
    logic [2:0]              cti;
    logic [1:0]              bte;
    logic                    ack;
    logic                    err;

    modport master (output cyc, stb, we, adr, sel, dat_w, cti, bte, input dat_r, ack, err);
    modport slave  (input cyc, stb, we, adr, sel, dat_w, cti, bte, output dat_r, ack, err);
endinterface

// File: rtl/or1200_wb_arb2.sv
// Round-robin, CYC-framed two-master Wishbone arbiter for the OR1200 iwb/dwb ports.
// Define OR1200_WB_ARB_TIMEOUT_EN to add the bus watchdog (ERR on hung transfers + DRAIN state).
module or1200_wb_arb2 #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rstn_i,
    wb_if.slave  m0,
    wb_if.slave  m1,
    wb_if.master s
);
    localparam int SEL_W = DATA_WIDTH / 8;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;
`ifdef OR1200_WB_ARB_TIMEOUT_EN
    localparam logic [1:0] DRAIN = 2'd3;
`endif

    generate
        if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
            $error("or1200_wb_arb2: TIMEOUT_CYCLES must be at least 2");
        end
    endgenerate

    logic [1:0]            state_q, state_d;
    logic                  last_gnt_q, last_gnt_d;
    logic                  timeout;
    logic                  cyc_mux, stb_mux, we_mux;
    logic [ADDR_WIDTH-1:0] adr_mux;
    logic [SEL_W-1:0]      sel_mux;
    logic [DATA_WIDTH-1:0] dat_w_mux;
    logic [2:0]            cti_mux;
    logic [1:0]            bte_mux;

    always_comb begin
        cyc_mux   = 1'b0;
        stb_mux   = 1'b0;
        we_mux    = 1'b0;
        adr_mux   = '0;
        sel_mux   = '0;
        dat_w_mux = '0;
        cti_mux   = '0;
        bte_mux   = '0;
        case (state_q)
            GNT0: begin
                cyc_mux   = m0.cyc;
                stb_mux   = m0.stb;
                we_mux    = m0.we;
                adr_mux   = m0.adr;
                sel_mux   = m0.sel;
                dat_w_mux = m0.dat_w;
                cti_mux   = m0.cti;
                bte_mux   = m0.bte;
            end
            GNT1: begin
                cyc_mux   = m1.cyc;
                stb_mux   = m1.stb;
                we_mux    = m1.we;
                adr_mux   = m1.adr;
                sel_mux   = m1.sel;
                dat_w_mux = m1.dat_w;
                cti_mux   = m1.cti;
                bte_mux   = m1.bte;
            end
            default: ;
        endcase
    end

    // A watchdog expiry withdraws the cycle from the slave in the same clock it reports ERR.
    assign s.cyc   = cyc_mux & ~timeout;
    assign s.stb   = stb_mux & ~timeout;
    assign s.we    = we_mux;
    assign s.adr   = adr_mux;
    assign s.sel   = sel_mux;
    assign s.dat_w = dat_w_mux;
    assign s.cti   = cti_mux;
    assign s.bte   = bte_mux;

    assign m0.ack   = (state_q == GNT0) & s.ack;
    assign m0.err   = (state_q == GNT0) & (s.err | timeout);
    assign m1.ack   = (state_q == GNT1) & s.ack;
    assign m1.err   = (state_q == GNT1) & (s.err | timeout);
    assign m0.dat_r = s.dat_r;
    assign m1.dat_r = s.dat_r;

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            IDLE: begin
                if (m0.cyc && (!m1.cyc || last_gnt_q)) state_d = GNT0;
                else if (m1.cyc)                        state_d = GNT1;
            end
            GNT0: begin
                if (!m0.cyc) begin
                    state_d    = IDLE;
                    last_gnt_d = 1'b0;
                end
`ifdef OR1200_WB_ARB_TIMEOUT_EN
                else if (timeout) begin
                    state_d    = DRAIN;
                    last_gnt_d = 1'b0;
                end
`endif
            end
            GNT1: begin
                if (!m1.cyc) begin
                    state_d    = IDLE;
                    last_gnt_d = 1'b1;
                end
`ifdef OR1200_WB_ARB_TIMEOUT_EN
                else if (timeout) begin
                    state_d    = DRAIN;
                    last_gnt_d = 1'b1;
                end
`endif
            end
`ifdef OR1200_WB_ARB_TIMEOUT_EN
            // last_gnt already names the timed-out owner; wait for it to abandon the cycle.
            DRAIN: begin
                if (!(last_gnt_q ? m1.cyc : m0.cyc)) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

`ifdef OR1200_WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             owned;

    assign owned   = (state_q == GNT0) || (state_q == GNT1);
    // Count includes the current stalled cycle, so ERR lands on the TIMEOUT_CYCLES-th one.
    assign timeout = owned && stb_mux && !s.ack && !s.err &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (!owned || (state_d != state_q) || s.ack || s.err) cnt_d = '0;
        else if (stb_mux)                                     cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif
endmodule
